// File: rtl/sw_debounce.sv
// Four-channel switch conditioner: two-flop synchroniser, per-channel
// stability counter and registered rise/fall pulses.
//
// Per-channel state (derived from the registers, not stored separately):
//   state     | meaning
//   ----------+----------------------------------------------------------
//   STABLE    | synchronised input equals debounced level, counter idle
//   COUNTING  | synchronised input differs from level, counting agreement
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_level,
  output logic [3:0] sw_rise,
  output logic [3:0] sw_fall
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [3:0]       s1, s2;
  logic [3:0]       db, db_nxt;
  logic [3:0]       rise, rise_nxt;
  logic [3:0]       fall, fall_nxt;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  ch_state_t        state   [4];

  // Classify each channel and compute its next counter, level and pulses.
  always_comb begin
    db_nxt   = db;
    rise_nxt = 4'b0000;
    fall_nxt = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      state[i]   = (s2[i] != db[i]) ? ST_COUNTING : ST_STABLE;
      case (state[i])
        ST_STABLE: begin
          cnt_nxt[i] = CNT_ZERO;
        end
        ST_COUNTING: begin
          if (cnt[i] == CNT_LAST) begin
            // Commit: the level follows s2 and exactly one pulse fires.
            db_nxt[i]   = s2[i];
            cnt_nxt[i]  = CNT_ZERO;
            rise_nxt[i] = s2[i];
            fall_nxt[i] = ~s2[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_nxt[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // Synchroniser and per-channel state registers; reset clears everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 4'b0000;
      s2   <= 4'b0000;
      db   <= 4'b0000;
      rise <= 4'b0000;
      fall <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= CNT_ZERO;
      end
    end else begin
      s1   <= sw_raw;
      s2   <= s1;
      db   <= db_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign sw_level = db;
  assign sw_rise  = rise;
  assign sw_fall  = fall;

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Four-channel switch conditioner that sits directly upstream of the `CPU` block. It synchronises the raw board switches to `clock`, filters contact bounce with a per-channel stability counter, and produces clean levels plus one-cycle rise/fall pulses. `sw_level[0]..sw_level[3]` drive the CPU `SW1`..`SW4` inputs. The pulses are available for edge-triggered control such as step or load.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles the synchronised input must differ from the current level before the level flips. Legal range is 2 or more.
- `CNT_W`, default 5: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- `clock`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `sw_raw`, input, 4: raw asynchronous switch inputs. Bit i is channel i.
- `sw_level`, output, 4: debounced level per channel.
- `sw_rise`, output, 4: one-cycle pulse when the debounced level goes 0→1.
- `sw_fall`, output, 4: one-cycle pulse when the debounced level goes 1→0.

## Operation

- Each of the 4 channels is independent and identical. There is no cross-channel interaction.
- Per-channel registers:
  - synchroniser `s1`, `s2`
  - debounced state `db`, which drives `sw_level[i]`
  - counter `cnt[CNT_W-1:0]`
  - pulse registers `rise` and `fall`
- On every rising edge:
  - `s1 <= sw_raw[i]`; `s2 <= s1`.
  - If `s2 == db`: `cnt <= 0`; `rise <= 0`; `fall <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`:
    - `db <= s2`; `cnt <= 0`
    - `rise <= s2`; `fall <= ~s2`
  - Else: `cnt <= cnt+1`; `rise <= 0`; `fall <= 0`.
- Per-channel states:
  - STABLE: `cnt == 0` and `s2 == db`.
  - COUNTING: `s2 != db`.
  - COUNTING → STABLE:
    - on commit, after DEBOUNCE_CYCLES consecutive mismatching edges, or
    - on abort, when a single matching sample resets `cnt`.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES cycles, measured at `s2`, produces no change on any output.
- Counter arithmetic is unsigned. `cnt` never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Reset (`reset_n` low, asynchronous, any time including mid-count) clears `s1`, `s2`, `db`, `cnt`, `rise` and `fall` to 0 immediately.
- After reset release with a switch already held at 1, the channel counts and commits normally. This produces one `sw_rise` pulse, so a held switch reads as a press.
- All outputs are direct register outputs. There is no combinational path from `sw_raw` or `reset_n` deassertion to any output.

## Timing

- Reset values: `sw_level` = 4'b0000, `sw_rise` = 4'b0000, `sw_fall` = 4'b0000.
- Latency, with edge 0 as the first edge that captures a new `sw_raw` value into `s1`:
  - `s2` updates at edge 1.
  - Mismatch edges run 1+1 through 1+DEBOUNCE_CYCLES.
  - `db` commits at edge DEBOUNCE_CYCLES+1.
  - `sw_level` changes in the cycle after edge DEBOUNCE_CYCLES+1. This is 17 edges after capture for the default of 16.
- `sw_rise[i]`/`sw_fall[i]`:
  - High for exactly one cycle, the same cycle in which `sw_level[i]` first shows the new value.
  - Never both high on one channel.
- Simultaneous changes on several channels commit on the same edge, with pulses asserted together.
- A return to the old level on the commit edge itself is not seen. `s2` is compared before update, so commit happens and the reverse transition starts counting afresh.
- Minimum spacing between consecutive pulses on one channel is DEBOUNCE_CYCLES+? cycles. Lower bound: DEBOUNCE_CYCLES cycles of stable opposite input.

## Test plan

Use DEBOUNCE_CYCLES=4, CNT_W=3 unless stated otherwise.

1. **Reset:** hold `reset_n`=0 with `sw_raw`=4'hF → all outputs 0. Release with `sw_raw`=4'hF → `sw_level` becomes 4'hF at edge 5 after release, and `sw_rise`=4'hF for exactly one cycle.
2. **Clean press:** `sw_raw[0]` 0→1, held → `sw_level[0]` rises after edge 5 from capture, with a single `sw_rise[0]` pulse. `sw_fall` stays 0. Other bits stay 0.
3. **Bounce rejection:** toggle `sw_raw[2]` 1,0,1,0 every 2 cycles, then hold 1 → no output change during toggling. Commit occurs only 5 edges after the final stable capture.
4. **Release and fall:** with `sw_level[1]`=1, drive `sw_raw[1]`=0 for 3 cycles then back to 1 → no `sw_fall`. Drive 0 for 10 cycles → one `sw_fall[1]` pulse and `sw_level[1]`=0.
5. **Simultaneous channels:** `sw_raw` 4'h0→4'hA on one edge → `sw_level`=4'hA and `sw_rise`=4'hA on the same cycle, with `sw_fall`=0.
6. **Reset mid-count:** start a 0→1 transition on `sw_raw[3]` and assert `reset_n`=0 at `cnt`=2 → outputs 0 immediately. After release, a full 5-edge count is required; there is no residual count.
